ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 310, width of one stored word and of m_axis_tdata.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 3, RAM address width; depth is 2**RAM_ADDR_BITS.
REQ-003 SHALL have parameter LAST_BIT, default 309, bit index within the word that carries tlast.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk and reset.
REQ-005 SHALL have port clk, input, 1, rising-edge clock for all logic.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port wr_ptr, input, RAM_ADDR_BITS+1, committed write pointer from the writer, MSB is the wrap bit.
REQ-008 SHALL have port rd_ptr, output, RAM_ADDR_BITS+1, released read pointer returned to the writer for its full check.
REQ-009 SHALL have port flush, input, 1, single-cycle request to discard all unread words.
REQ-010 SHALL have port enB, output, 1, RAM read-port enable.
REQ-011 SHALL have port addrB, output, RAM_ADDR_BITS, RAM read-port address.
REQ-012 SHALL have port doutB, input, RAM_WIDTH, RAM read data, valid one cycle after enB.
REQ-013 SHALL have ports m_axis_tdata (output, RAM_WIDTH), m_axis_tlast (output, 1), m_axis_tvalid (output, 1) and m_axis_tready (input, 1), forming the AXI4-Stream master output.

Function
REQ-014 SHALL keep an issue pointer iss_ptr (RAM_ADDR_BITS+1 bits) and treat the RAM as empty when iss_ptr equals wr_ptr on all bits.
REQ-015 SHALL define pop as m_axis_tvalid AND m_axis_tready, and occ as the buffered words (0-2) plus the in-flight reads (0-1).
REQ-016 SHALL assert enB in a cycle only when flush is low, the RAM is not empty, and occ minus pop is less than 2.
REQ-017 SHALL drive addrB with iss_ptr[RAM_ADDR_BITS-1:0] and SHALL increment iss_ptr modulo 2**(RAM_ADDR_BITS+1) in every enB cycle.
REQ-018 SHALL capture doutB in the cycle after enB: into the output register when that register is empty or popping, otherwise into a one-entry skid register.
REQ-019 SHALL refill the output register from the skid register on pop, so words leave in strict address order with no loss and no duplication.
REQ-020 SHALL sustain one word per cycle while m_axis_tready stays high and data is available; the first word appears on m_axis_tvalid 2 cycles after the RAM becomes non-empty.
REQ-021 SHALL hold m_axis_tdata and m_axis_tlast stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-022 SHALL drive m_axis_tlast equal to m_axis_tdata[LAST_BIT].
REQ-023 SHALL increment rd_ptr modulo 2**(RAM_ADDR_BITS+1) on each pop, so an entry is released only after it has been delivered.
REQ-024 On flush, SHALL in the next cycle show m_axis_tvalid low, with both buffer entries empty, any in-flight read discarded, and iss_ptr and rd_ptr loaded with wr_ptr.
REQ-025 SHALL give flush priority over a pop or a read return in the same cycle.
REQ-026 SHALL accept a wr_ptr that only moves forward; a backward move is a protocol violation and its behaviour is undefined.

Reset
REQ-027 On reset, SHALL in the next cycle clear m_axis_tvalid, m_axis_tdata, enB, addrB, iss_ptr, rd_ptr, both buffer entries, the in-flight flag and the statistics counters to 0.
REQ-028 SHALL give reset priority over flush and discard all buffered data, including when asserted mid-packet.

Configuration
REQ-029 With RAM_STREAM_READER_STATS_EN defined, SHALL provide outputs pkt_count[31:0] (counts pops with m_axis_tlast high) and word_count[31:0] (counts all pops), both wrapping at 2**32 and left unchanged by flush.
REQ-030 Without RAM_STREAM_READER_STATS_EN, SHALL omit both ports and their counters, with all other behaviour identical.

Verification
REQ-031 Reset, then wr_ptr 0->3 with tready held at 1 -> words at addresses 0, 1, 2 on three consecutive cycles, first tvalid 2 cycles after wr_ptr changes, rd_ptr ends at 3.
REQ-032 Eight words written, tready held at 0 -> occ stays at 2, enB deasserts, tdata stays at word 0; tready then set to 1 -> words 0-7 delivered back-to-back.
REQ-033 Wrap: pointers start at 6, wr_ptr advances to 10 (binary 1010) -> addrB sequence 6, 7, 0, 1; rd_ptr ends at 10.
REQ-034 flush while tvalid=1 with the skid register full -> next cycle tvalid=0 and rd_ptr equals wr_ptr; no stale word appears afterwards.
REQ-035 Reset asserted mid-packet at word 3 of 5 -> next cycle tvalid=0 and pointers 0; with STATS_EN, pkt_count=0 and word_count=0.
REQ-036 With STATS_EN, two packets of 3 and 1 words delivered -> pkt_count=2 and word_count=4.

Source files
------------

// File: rtl/ram_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_stream_reader: drains words from a RAM read port onto AXI4-Stream,   |
// | with a 2-entry output/skid buffer. Optional stats: RAM_STREAM_READER_STATS_EN |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ram_stream_reader #(
  parameter int RAM_WIDTH     = 310,
  parameter int RAM_ADDR_BITS = 3,
  parameter int LAST_BIT      = 309
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RAM_ADDR_BITS:0]   wr_ptr,
  output logic [RAM_ADDR_BITS:0]   rd_ptr,
  input  logic                     flush,
  output logic                     enB,
  output logic [RAM_ADDR_BITS-1:0] addrB,
  input  logic [RAM_WIDTH-1:0]     doutB,
  output logic [RAM_WIDTH-1:0]     m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
`ifdef RAM_STREAM_READER_STATS_EN
  ,
  output logic [31:0]              pkt_count,
  output logic [31:0]              word_count
`endif
);

  localparam logic [RAM_ADDR_BITS:0] c_ptr_one = 1;

  logic [RAM_ADDR_BITS:0] r_iss_ptr;
  logic [RAM_ADDR_BITS:0] r_rd_ptr;
  logic                   r_out_valid;
  logic [RAM_WIDTH-1:0]   r_out_data;
  logic                   r_skid_valid;
  logic [RAM_WIDTH-1:0]   r_skid_data;
  logic                   r_inflight;

  logic       w_pop;
  logic       w_empty;
  logic [1:0] w_occ;
  logic       w_en;

  assign w_pop   = r_out_valid & m_axis_tready;
  assign w_empty = (r_iss_ptr == wr_ptr);
  assign w_occ   = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_inflight};
  // Issue only when the word, once returned, is guaranteed a buffer slot.
  assign w_en    = !flush && !w_empty && ((w_occ - {1'b0, w_pop}) < 2'd2);

  assign enB           = w_en;
  assign addrB         = r_iss_ptr[RAM_ADDR_BITS-1:0];
  assign rd_ptr        = r_rd_ptr;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tlast  = r_out_data[LAST_BIT];
  assign m_axis_tvalid = r_out_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_iss_ptr    <= '0;
      r_rd_ptr     <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_inflight   <= 1'b0;
    end else if (flush) begin
      r_iss_ptr    <= wr_ptr;
      r_rd_ptr     <= wr_ptr;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_en;
      if (w_en) begin
        r_iss_ptr <= r_iss_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
        // Skid drains first so a simultaneous return keeps address order.
        if (r_skid_valid) begin
          r_out_data <= r_skid_data;
          if (r_inflight) begin
            r_skid_data <= doutB;
          end else begin
            r_skid_valid <= 1'b0;
          end
        end else if (r_inflight) begin
          r_out_data <= doutB;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (r_inflight) begin
        if (r_out_valid) begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= doutB;
        end else begin
          r_out_valid <= 1'b1;
          r_out_data  <= doutB;
        end
      end
    end
  end

`ifdef RAM_STREAM_READER_STATS_EN
  logic [31:0] r_pkt_count;
  logic [31:0] r_word_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_count  <= '0;
      r_word_count <= '0;
    end else if (!flush && w_pop) begin
      r_word_count <= r_word_count + 32'd1;
      if (m_axis_tlast) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end
  end

  assign pkt_count  = r_pkt_count;
  assign word_count = r_word_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// Bench for ram_stream_reader: RAM model, writer, and scoreboarded AXI-Stream sink.
module tb_ram_stream_reader;

  localparam int W  = 310;
  localparam int AB = 3;
  localparam int LB = 309;

  logic          clk = 1'b0;
  logic          reset;
  logic [AB:0]   wr_ptr;
  logic [AB:0]   rd_ptr;
  logic          flush;
  logic          enB;
  logic [AB-1:0] addrB;
  logic [W-1:0]  doutB;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;

  ram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .LAST_BIT(LB)) dut (
    .clk(clk), .reset(reset), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .flush(flush),
    .enB(enB), .addrB(addrB), .doutB(doutB),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:(1<<AB)-1];
  always @(posedge clk) if (enB) doutB <= mem[addrB];

  int n_cmp = 0;
  int n_err = 0;
  int n_last = 0;
  logic [W-1:0] q [$];
  logic [W-1:0] e;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard sink: every handshake must match the oldest written word.
  always @(negedge clk) begin
    if (!reset && !flush && m_axis_tvalid && m_axis_tready) begin
      if (q.size() == 0) fail("unexpected_word");
      else begin
        e = q.pop_front();
        check("tdata", m_axis_tdata, e);
        check("tlast", m_axis_tlast, e[LB]);
      end
      if (m_axis_tlast) n_last++;
    end
  end

  task automatic write_words(input int n, input logic [7:0] mask);
    logic [AB:0]   used;
    logic [319:0]  r;
    logic [W-1:0]  w;
    used = wr_ptr - rd_ptr;
    if (int'(used) + n > 8) begin
      fail("write_overrun");
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom;
      w = r[W-1:0];
      w[LB] = mask[i];
      mem[3'(wr_ptr + 4'(i))] = w;
      q.push_back(w);
    end
    @(posedge clk); #1;
    wr_ptr = wr_ptr + 4'(n);
  endtask

  task automatic drain(input int mode);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk); #1;
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'(c & 1);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (q.size() == 0 && !m_axis_tvalid) done = 1'b1;
    end
    if (!done) fail("drain_timeout");
  endtask

  typedef struct {
    int         n;
    logic [7:0] mask;
    int         mode;
    int         exp_lasts;
  } vec_t;

  vec_t vecs [5];
  logic [AB:0] exp_rd;
  logic [AB:0] addr_seen [4];
  logic [AB:0] addr_exp  [4];
  logic        vexp [6];
  int          cnt;

  initial begin
    vecs[0] = '{3, 8'b0000_0100, 0, 1};
    vecs[1] = '{5, 8'b0001_0010, 1, 2};
    vecs[2] = '{8, 8'b1111_1111, 2, 8};
    vecs[3] = '{6, 8'b0000_0000, 1, 0};
    vecs[4] = '{7, 8'b0100_0001, 2, 2};
    addr_exp[0] = 4'd6; addr_exp[1] = 4'd7; addr_exp[2] = 4'd0; addr_exp[3] = 4'd1;
    vexp[0] = 0; vexp[1] = 0; vexp[2] = 1; vexp[3] = 1; vexp[4] = 1; vexp[5] = 0;

    reset = 1'b1; flush = 1'b0; wr_ptr = '0; m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_rd_ptr", rd_ptr, 0);
    check("rst_enB", enB, 0);
    check("rst_addrB", addrB, 0);
    check("rst_tdata", m_axis_tdata, 0);

    // First-word latency: 2 cycles after the RAM turns non-empty.
    m_axis_tready = 1'b1;
    write_words(3, 8'b100);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("lat_enB0", enB, 1);
        check("lat_addrB0", addrB, 0);
      end
      check($sformatf("lat_tvalid_c%0d", c), m_axis_tvalid, vexp[c]);
    end
    check("lat_rd_ptr", rd_ptr, 3);

    // Backpressure: buffer holds two words, issue stops, head word stays put.
    @(posedge clk); #1 m_axis_tready = 1'b0;
    write_words(8, 8'b1000_0000);
    repeat (6) @(negedge clk);
    e = q[0];
    for (int c = 0; c < 3; c++) begin
      check("bp_enB", enB, 0);
      check("bp_tvalid", m_axis_tvalid, 1);
      check("bp_tdata_hold", m_axis_tdata, e);
      @(negedge clk);
    end
    @(posedge clk); #1 m_axis_tready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) cnt++;
    end
    check("bp_back_to_back", cnt, 8);
    @(negedge clk);
    check("bp_done_tvalid", m_axis_tvalid, 0);
    check("bp_rd_ptr", rd_ptr, 11);

    // Wrap: move both pointers to 6 via flush, then advance to 10.
    @(posedge clk); #1 wr_ptr = 4'd6; flush = 1'b1; q.delete();
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("wrap_start_rd", rd_ptr, 6);
    write_words(4, 8'b1000);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (enB && cnt < 4) begin
        addr_seen[cnt] = {1'b0, addrB};
        cnt++;
      end
    end
    check("wrap_issue_cnt", cnt, 4);
    for (int i = 0; i < 4; i++) check($sformatf("wrap_addrB%0d", i), addr_seen[i], addr_exp[i]);
    drain(0);
    check("wrap_rd_ptr", rd_ptr, 10);

    // Flush with output and skid both full.
    @(posedge clk); #1 m_axis_tready = 1'b0;
    write_words(4, 8'b0);
    repeat (6) @(negedge clk);
    check("fl_pre_tvalid", m_axis_tvalid, 1);
    @(posedge clk); #1 flush = 1'b1; q.delete();
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("fl_tvalid", m_axis_tvalid, 0);
    check("fl_rd_eq_wr", rd_ptr, wr_ptr);
    m_axis_tready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) cnt++;
    end
    check("fl_no_stale", cnt, 0);
    write_words(2, 8'b10);
    drain(0);
    check("fl_rd_after", rd_ptr, 4'd0);

    // Reset mid-packet while word 3 of 5 is presented.
    @(posedge clk); #1 m_axis_tready = 1'b0;
    write_words(5, 8'b1_0000);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 m_axis_tready = 1'b0;
    check("mid_tvalid_pre", m_axis_tvalid, 1);
    reset = 1'b1; wr_ptr = '0; q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_tvalid", m_axis_tvalid, 0);
    check("mid_rd_ptr", rd_ptr, 0);
    check("mid_enB", enB, 0);
    check("mid_tdata", m_axis_tdata, 0);

    // Table of bursts with varied tlast patterns and ready duty cycles.
    exp_rd = '0;
    foreach (vecs[v]) begin
      n_last = 0;
      write_words(vecs[v].n, vecs[v].mask);
      drain(vecs[v].mode);
      exp_rd = exp_rd + 4'(vecs[v].n);
      check($sformatf("vec%0d_rd_ptr", v), rd_ptr, exp_rd);
      check($sformatf("vec%0d_lasts", v), n_last, vecs[v].exp_lasts);
      @(posedge clk); #1 m_axis_tready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
